rx_word_fifo: RTL

- Sits between the UART byte receiver and the write-back/PC-generate stage, in place of the single-word receive buffer.
- Packs received bytes into 32-bit words, most significant byte first, and queues them in a first-word-fall-through FIFO.
- Write-back pops one word per retired UART-to-register instruction.
- Reports overflow and partial-word status for debug LEDs.

---
 rtl/rx_word_fifo.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rx_word_fifo.sv
// ============================================================================
// rx_word_fifo
// ----------------------------------------------------------------------------
// Packs bytes from the UART receiver into 32-bit words (first byte received
// lands in bits [31:24]) and queues the words in a first-word-fall-through
// FIFO of 2**DEPTH_LOG2 entries. The write-back stage pops one word per
// retired UART-to-register instruction. Sticky flags report a dropped
// complete word (FIFO full) and, optionally, a partial word discarded by an
// inter-byte timeout.
//
// Optional feature macro: RX_PARTIAL_TIMEOUT_EN
//   defined   : a partial word idle for TIMEOUT_CYCLES cycles is discarded
//               and partial_drop is set.
//   undefined : a partial word waits indefinitely; partial_drop is tied 0.
//
// Ports:
//   CLK           in   1             clock
//   reset         in   1             synchronous, active-high reset
//   rx_data       in   8             byte from the UART receiver
//   rx_valid      in   1             one-cycle pulse, rx_data valid
//   pop           in   1             consume head word (ignored when empty)
//   word_data     out  32            head word, 32'h0 when empty
//   word_ready    out  1             FIFO non-empty
//   count         out  DEPTH_LOG2+1  words held, 0..2**DEPTH_LOG2
//   byte_phase    out  2             bytes collected toward current word
//   overflow      out  1             sticky: complete word dropped (full)
//   partial_drop  out  1             sticky: partial word dropped (timeout)
// ============================================================================
module rx_word_fifo #(
    parameter int DEPTH_LOG2     = 3,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  pop,
    output logic [31:0]           word_data,
    output logic                  word_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic [1:0]            byte_phase,
    output logic                  overflow,
    output logic                  partial_drop
);

    localparam int                 DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    // Storage is deliberately not reset; count alone decides what is valid.
    logic [31:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_count;
    logic [1:0]             r_phase;
    // Only the three most recent bytes are ever needed: the fourth byte is
    // taken straight from rx_data when the word completes.
    logic [23:0]            r_asm;
    logic                   r_overflow;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push_ok;
    logic                   w_drop;
    logic                   w_timeout;
    logic [31:0]            w_word;
    logic [DEPTH_LOG2:0]    w_count_nxt;

    assign w_word    = {r_asm, rx_data};
    assign w_push    = rx_valid && (r_phase == 2'd3);
    assign w_pop     = pop && (r_count != CNT_ZERO);
    assign w_full    = (r_count == CNT_FULL);
    // A push into a full FIFO still succeeds when the head leaves this edge.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Occupancy for the next cycle from this cycle's accepted push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push_ok) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FIFO pointers, occupancy, byte assembly and overflow flag.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr   <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr   <= {DEPTH_LOG2{1'b0}};
            r_count    <= CNT_ZERO;
            r_phase    <= 2'd0;
            r_asm      <= 24'h0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            // A byte arriving on the expiry cycle takes priority over timeout.
            if (rx_valid) begin
                r_phase <= r_phase + 2'd1;
                r_asm   <= {r_asm[15:0], rx_data};
            end else if (w_timeout) begin
                r_phase <= 2'd0;
                r_asm   <= 24'h0;
            end
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Word storage write; reset blocks the write along with everything else.
    always_ff @(posedge CLK) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

`ifdef RX_PARTIAL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_partial_drop;

    assign w_timeout = (r_phase != 2'd0) && !rx_valid &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter for a partially assembled word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (rx_valid || w_timeout || (r_phase == 2'd0)) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Sticky record that a partial word was discarded.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_partial_drop <= 1'b0;
        end else begin
            r_partial_drop <= r_partial_drop | w_timeout;
        end
    end

    assign partial_drop = r_partial_drop;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign partial_drop     = 1'b0;
`endif

    assign word_data  = (r_count == CNT_ZERO) ? 32'h0 : r_mem[r_rd_ptr];
    assign word_ready = (r_count != CNT_ZERO);
    assign count      = r_count;
    assign byte_phase = r_phase;
    assign overflow   = r_overflow;

endmodule
